axi4_lite_xbar: RTL and testbench

- Parametrised successor to the fixed 4-subordinate AXI4-Lite crossbar: one manager port fanned out to N_SUB subordinate ports.
- Base addresses and window sizes are set per port.
- Adds behaviour the fixed crossbar lacks: DECERR for unmapped addresses, a per-channel response timeout returning SLVERR, and independent read/write channels.
- Sits between axi4_lite_manager and the SoC peripherals (GPIO, VGA, UART, timers).

---
 rtl/axi4_lite_xbar_pkg.sv | 20 ++
 rtl/axi4_lite_xbar_decode.sv | 36 +++
 rtl/axi4_lite_xbar.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4_lite_xbar.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_xbar_pkg.sv
// Shared AXI4-Lite response/FSM types and the default SoC address map for the crossbar.
package axi4_lite_xbar_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [2:0] {W_IDLE, W_COLLECT, W_FWD, W_WAIT, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_RESP} rd_state_t;

   // Default SoC map: four 4 KiB windows (GPIO, VGA, UART, timers)
   localparam int MAP_N_SUB = 4;
   localparam logic [MAP_N_SUB*32-1:0] MAP_SUB_BASE_ADDR =
      {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
   localparam logic [MAP_N_SUB*8-1:0] MAP_SUB_ADDR_WIDTH = {4{8'd12}};

endpackage

// File: rtl/axi4_lite_xbar_decode.sv
// Address window decoder: one-hot select, index, miss flag and window-local offset.
module axi4_lite_xbar_decode
   import axi4_lite_xbar_pkg::*;
#(
   parameter int N_SUB = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int IDX_W = 2,
   parameter logic [N_SUB*ADDR_WIDTH-1:0] SUB_BASE_ADDR = '0,
   parameter logic [N_SUB*8-1:0] SUB_ADDR_WIDTH = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [N_SUB-1:0]      sel_oh,
   output logic [IDX_W-1:0]      sel_idx,
   output logic                  miss,
   output logic [ADDR_WIDTH-1:0] local_addr
);

   // Scan from the top index down so the lowest matching window wins on overlap
   always_comb begin
      sel_oh     = '0;
      sel_idx    = '0;
      miss       = 1'b1;
      local_addr = '0;
      for (int i = N_SUB - 1; i >= 0; i--) begin
         if ((addr >> SUB_ADDR_WIDTH[i*8 +: 8]) ==
             (SUB_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] >> SUB_ADDR_WIDTH[i*8 +: 8])) begin
            sel_oh     = '0;
            sel_oh[i]  = 1'b1;
            sel_idx    = IDX_W'(i);
            miss       = 1'b0;
            local_addr = addr & ~({ADDR_WIDTH{1'b1}} << SUB_ADDR_WIDTH[i*8 +: 8]);
         end
      end
   end

endmodule

// File: rtl/axi4_lite_xbar.sv
// AXI4-Lite 1-to-N crossbar with independent read/write FSMs, decode error and response timeout.
module axi4_lite_xbar
   import axi4_lite_xbar_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int N_SUB = 4,
   parameter logic [N_SUB*ADDR_WIDTH-1:0] SUB_BASE_ADDR = MAP_SUB_BASE_ADDR,
   parameter logic [N_SUB*8-1:0] SUB_ADDR_WIDTH = MAP_SUB_ADDR_WIDTH,
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic [ADDR_WIDTH-1:0]   m_awaddr,
   input  logic                    m_awvalid,
   output logic                    m_awready,
   input  logic [DATA_WIDTH-1:0]   m_wdata,
   input  logic [DATA_WIDTH/8-1:0] m_wstrb,
   input  logic                    m_wvalid,
   output logic                    m_wready,
   output logic [1:0]              m_bresp,
   output logic                    m_bvalid,
   input  logic                    m_bready,
   input  logic [ADDR_WIDTH-1:0]   m_araddr,
   input  logic                    m_arvalid,
   output logic                    m_arready,
   output logic [DATA_WIDTH-1:0]   m_rdata,
   output logic [1:0]              m_rresp,
   output logic                    m_rvalid,
   input  logic                    m_rready,
   output logic [N_SUB-1:0][ADDR_WIDTH-1:0]   s_awaddr,
   output logic [N_SUB-1:0]                   s_awvalid,
   input  logic [N_SUB-1:0]                   s_awready,
   output logic [N_SUB-1:0][DATA_WIDTH-1:0]   s_wdata,
   output logic [N_SUB-1:0][DATA_WIDTH/8-1:0] s_wstrb,
   output logic [N_SUB-1:0]                   s_wvalid,
   input  logic [N_SUB-1:0]                   s_wready,
   input  logic [N_SUB-1:0][1:0]              s_bresp,
   input  logic [N_SUB-1:0]                   s_bvalid,
   output logic [N_SUB-1:0]                   s_bready,
   output logic [N_SUB-1:0][ADDR_WIDTH-1:0]   s_araddr,
   output logic [N_SUB-1:0]                   s_arvalid,
   input  logic [N_SUB-1:0]                   s_arready,
   input  logic [N_SUB-1:0][DATA_WIDTH-1:0]   s_rdata,
   input  logic [N_SUB-1:0][1:0]              s_rresp,
   input  logic [N_SUB-1:0]                   s_rvalid,
   output logic [N_SUB-1:0]                   s_rready
);

   localparam int IDX_W = (N_SUB > 1) ? $clog2(N_SUB) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   wr_state_t w_state;
   rd_state_t r_state;
   logic out_en;
   logic aw_have, w_have, aw_pend, w_pend;
   logic [CNT_W-1:0] w_cnt, r_cnt;
   axi_resp_t bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0]   rdata_q, wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;

   logic [N_SUB-1:0] w_sel_oh, r_sel_oh;
   logic [IDX_W-1:0] w_sel, r_sel;
   logic w_miss, r_miss;
   logic [ADDR_WIDTH-1:0] w_local, r_local;
   logic aw_fire, w_fire, ar_fire, w_timeout, r_timeout;

   axi4_lite_xbar_decode #(.N_SUB(N_SUB), .ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W),
      .SUB_BASE_ADDR(SUB_BASE_ADDR), .SUB_ADDR_WIDTH(SUB_ADDR_WIDTH)) u_w_decode (
      .addr(awaddr_q), .sel_oh(w_sel_oh), .sel_idx(w_sel), .miss(w_miss), .local_addr(w_local));

   axi4_lite_xbar_decode #(.N_SUB(N_SUB), .ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W),
      .SUB_BASE_ADDR(SUB_BASE_ADDR), .SUB_ADDR_WIDTH(SUB_ADDR_WIDTH)) u_r_decode (
      .addr(araddr_q), .sel_oh(r_sel_oh), .sel_idx(r_sel), .miss(r_miss), .local_addr(r_local));

   // Readies stay low during reset and the first cycle after it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_en <= 1'b0;
      else     out_en <= 1'b1;
   end

   assign m_awready = out_en && (w_state == W_IDLE || w_state == W_COLLECT) && !aw_have;
   assign m_wready  = out_en && (w_state == W_IDLE || w_state == W_COLLECT) && !w_have;
   assign m_arready = out_en && (r_state == R_IDLE);
   assign aw_fire   = m_awvalid && m_awready;
   assign w_fire    = m_wvalid && m_wready;
   assign ar_fire   = m_arvalid && m_arready;
   assign w_timeout = (TIMEOUT != 0) && (w_cnt == CNT_LAST);
   assign r_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

   assign s_awvalid = (w_state == W_FWD && aw_pend) ? w_sel_oh : '0;
   assign s_wvalid  = (w_state == W_FWD && w_pend) ? w_sel_oh : '0;
   assign s_arvalid = (r_state == R_FWD) ? r_sel_oh : '0;
   assign s_bready  = !out_en ? '0 :
                      (w_state == W_IDLE || w_state == W_COLLECT) ? '1 :
                      (w_state == W_WAIT) ? w_sel_oh : '0;
   assign s_rready  = !out_en ? '0 : (r_state == R_IDLE) ? '1 :
                      (r_state == R_WAIT) ? r_sel_oh : '0;
   assign m_bvalid  = (w_state == W_RESP);
   assign m_rvalid  = (r_state == R_RESP);
   assign m_bresp   = bresp_q;
   assign m_rresp   = rresp_q;
   assign m_rdata   = rdata_q;

   for (genvar i = 0; i < N_SUB; i++) begin : g_fanout
      assign s_awaddr[i] = w_local;
      assign s_wdata[i]  = wdata_q;
      assign s_wstrb[i]  = wstrb_q;
      assign s_araddr[i] = r_local;
   end

   always_ff @(posedge clk) begin
      if (aw_fire) awaddr_q <= m_awaddr;
      if (w_fire) begin
         wdata_q <= m_wdata;
         wstrb_q <= m_wstrb;
      end
      if (ar_fire) araddr_q <= m_araddr;
   end

   // Decode misses are resolved in the first FWD cycle, where no subordinate valid is raised
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state <= W_IDLE;
         aw_have <= 1'b0;
         w_have  <= 1'b0;
         aw_pend <= 1'b0;
         w_pend  <= 1'b0;
         w_cnt   <= '0;
         bresp_q <= OKAY;
      end else begin
         case (w_state)
            W_IDLE, W_COLLECT: begin
               if (aw_fire) aw_have <= 1'b1;
               if (w_fire)  w_have  <= 1'b1;
               if ((aw_have || aw_fire) && (w_have || w_fire)) begin
                  w_state <= W_FWD;
                  aw_have <= 1'b0;
                  w_have  <= 1'b0;
                  aw_pend <= 1'b1;
                  w_pend  <= 1'b1;
                  w_cnt   <= '0;
               end else if (aw_fire || w_fire) begin
                  w_state <= W_COLLECT;
               end
            end
            W_FWD: begin
               if (w_miss || w_timeout) begin
                  bresp_q <= w_miss ? DECERR : SLVERR;
                  aw_pend <= 1'b0;
                  w_pend  <= 1'b0;
                  w_state <= W_RESP;
               end else begin
                  if (s_awready[w_sel]) aw_pend <= 1'b0;
                  if (s_wready[w_sel])  w_pend  <= 1'b0;
                  if ((!aw_pend || s_awready[w_sel]) && (!w_pend || s_wready[w_sel]))
                     w_state <= W_WAIT;
                  w_cnt <= w_cnt + 1'b1;
               end
            end
            W_WAIT: begin
               if (s_bvalid[w_sel]) begin
                  bresp_q <= axi_resp_t'(s_bresp[w_sel]);
                  w_state <= W_RESP;
               end else if (w_timeout) begin
                  bresp_q <= SLVERR;
                  w_state <= W_RESP;
               end else begin
                  w_cnt <= w_cnt + 1'b1;
               end
            end
            W_RESP:  if (m_bready) w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= R_IDLE;
         r_cnt   <= '0;
         rresp_q <= OKAY;
         rdata_q <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (ar_fire) begin
               r_state <= R_FWD;
               r_cnt   <= '0;
            end
            R_FWD: begin
               if (r_miss || r_timeout) begin
                  rresp_q <= r_miss ? DECERR : SLVERR;
                  rdata_q <= '0;
                  r_state <= R_RESP;
               end else begin
                  if (s_arready[r_sel]) r_state <= R_WAIT;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            R_WAIT: begin
               if (s_rvalid[r_sel]) begin
                  rresp_q <= axi_resp_t'(s_rresp[r_sel]);
                  rdata_q <= s_rdata[r_sel];
                  r_state <= R_RESP;
               end else if (r_timeout) begin
                  rresp_q <= SLVERR;
                  rdata_q <= '0;
                  r_state <= R_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            R_RESP:  if (m_rready) r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_xbar.sv
// Directed bench for axi4_lite_xbar: 4 windows of 4 KiB at 0x0000..0x3000, TIMEOUT=8.
module tb_axi4_lite_xbar;

   logic clk, rst;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [3:0]  m_wstrb;
   logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic m_arvalid, m_arready, m_rvalid, m_rready;
   logic [1:0] m_bresp, m_rresp;
   logic [3:0][31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [3:0][3:0]  s_wstrb;
   logic [3:0][1:0]  s_bresp, s_rresp;
   logic [3:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [3:0] s_arvalid, s_arready, s_rvalid, s_rready;

   int total = 0;
   int bad = 0;

   axi4_lite_xbar #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_SUB(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++; if (m_awready !== 1'b0) begin bad++; $display("FAIL rst_awready got=%b exp=0", m_awready); end
      total++; if (m_arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%b exp=0", m_arready); end
      total++; if (s_bready !== 4'b0000) begin bad++; $display("FAIL rst_s_bready got=%b exp=0000", s_bready); end
      total++; if ({m_bvalid, m_rvalid, s_awvalid, s_arvalid} !== 10'b0) begin bad++; $display("FAIL rst_valids got=%b exp=0", {m_bvalid, m_rvalid, s_awvalid, s_arvalid}); end
      total++; if ({m_bresp, m_rresp, m_rdata} !== 36'h0) begin bad++; $display("FAIL rst_resp got=%h exp=0", {m_bresp, m_rresp, m_rdata}); end
      rst = 1'b0;
      tick();
      tick();
      total++; if ({m_awready, m_wready, m_arready} !== 3'b111) begin bad++; $display("FAIL idle_ready got=%b exp=111", {m_awready, m_wready, m_arready}); end
      total++; if (s_bready !== 4'b1111 || s_rready !== 4'b1111) begin bad++; $display("FAIL idle_s_ready got=%b/%b exp=1111/1111", s_bready, s_rready); end
   endtask

   task automatic test_write_same_cycle();
      s_bresp[0] = 2'b01; s_bresp[1] = 2'b10; s_bresp[2] = 2'b00; s_bresp[3] = 2'b10;
      m_awaddr = 32'h2004; m_awvalid = 1'b1;
      m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF; m_wvalid = 1'b1; m_bready = 1'b1;
      tick();
      m_awvalid = 1'b0; m_wvalid = 1'b0;
      total++; if (s_awvalid !== 4'b0100 || s_wvalid !== 4'b0100) begin bad++; $display("FAIL wr_fwd_valid got=%b/%b exp=0100/0100", s_awvalid, s_wvalid); end
      total++; if (s_awaddr[2] !== 32'h004) begin bad++; $display("FAIL wr_offset got=%h exp=00000004", s_awaddr[2]); end
      total++; if (s_wdata[2] !== 32'hDEAD_BEEF || s_wstrb[2] !== 4'hF) begin bad++; $display("FAIL wr_data got=%h/%h exp=deadbeef/f", s_wdata[2], s_wstrb[2]); end
      tick();
      total++; if (s_awvalid !== 4'b0000 || s_bready !== 4'b0100) begin bad++; $display("FAIL wr_wait got=%b/%b exp=0000/0100", s_awvalid, s_bready); end
      s_bvalid = 4'b0100;
      tick();
      s_bvalid = 4'b0000;
      total++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b00) begin bad++; $display("FAIL wr_bresp got=%b/%b exp=1/00", m_bvalid, m_bresp); end
      tick();
      total++; if (m_bvalid !== 1'b0 || s_awvalid !== 4'b0000) begin bad++; $display("FAIL wr_done got=%b/%b exp=0/0000", m_bvalid, s_awvalid); end
   endtask

   task automatic test_w_before_aw();
      int nb;
      m_wdata = 32'h1234_5678; m_wstrb = 4'h3; m_wvalid = 1'b1;
      tick();
      m_wvalid = 1'b0;
      total++; if (m_wready !== 1'b0 || m_awready !== 1'b1 || s_wvalid !== 4'b0) begin bad++; $display("FAIL wfirst_collect got=%b/%b/%b exp=0/1/0000", m_wready, m_awready, s_wvalid); end
      m_awaddr = 32'h1010; m_awvalid = 1'b1;
      tick();
      m_awvalid = 1'b0;
      total++; if (s_awvalid !== 4'b0010 || s_awaddr[1] !== 32'h010) begin bad++; $display("FAIL wfirst_fwd got=%b/%h exp=0010/00000010", s_awvalid, s_awaddr[1]); end
      total++; if (s_wdata[1] !== 32'h1234_5678 || s_wstrb[1] !== 4'h3) begin bad++; $display("FAIL wfirst_data got=%h/%h exp=12345678/3", s_wdata[1], s_wstrb[1]); end
      tick();
      s_bresp[1] = 2'b00;
      s_bvalid = 4'b0010;
      tick();
      s_bvalid = 4'b0000;
      nb = 0;
      for (int k = 0; k < 5; k++) begin
         if (m_bvalid === 1'b1) nb++;
         tick();
      end
      total++; if (nb !== 1) begin bad++; $display("FAIL wfirst_b_count got=%0d exp=1", nb); end
   endtask

   task automatic test_read_ok();
      s_rdata[0] = 32'hCAFE_F00D; s_rdata[1] = 32'h1111_1111; s_rdata[2] = 32'h2222_2222; s_rdata[3] = 32'h3333_3333;
      s_rresp = {2'b10, 2'b10, 2'b10, 2'b00};
      m_araddr = 32'h0ABC; m_arvalid = 1'b1; m_rready = 1'b1;
      tick();
      m_arvalid = 1'b0;
      total++; if (s_arvalid !== 4'b0001 || s_araddr[0] !== 32'hABC) begin bad++; $display("FAIL rd_fwd got=%b/%h exp=0001/00000abc", s_arvalid, s_araddr[0]); end
      tick();
      total++; if (s_rready !== 4'b0001) begin bad++; $display("FAIL rd_wait_rready got=%b exp=0001", s_rready); end
      s_rvalid = 4'b0001;
      tick();
      s_rvalid = 4'b0000;
      total++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hCAFE_F00D || m_rresp !== 2'b00) begin bad++; $display("FAIL rd_data got=%b/%h/%b exp=1/cafef00d/00", m_rvalid, m_rdata, m_rresp); end
      tick();
   endtask

   task automatic test_read_decerr();
      m_araddr = 32'h8000; m_arvalid = 1'b1; m_rready = 1'b1;
      tick();
      m_arvalid = 1'b0;
      total++; if (s_arvalid !== 4'b0000 || m_rvalid !== 1'b0) begin bad++; $display("FAIL decerr_t1 got=%b/%b exp=0000/0", s_arvalid, m_rvalid); end
      tick();
      total++; if (m_rvalid !== 1'b1 || m_rresp !== 2'b11 || m_rdata !== 32'h0) begin bad++; $display("FAIL decerr_resp got=%b/%b/%h exp=1/11/00000000", m_rvalid, m_rresp, m_rdata); end
      tick();
   endtask

   task automatic test_timeout();
      int n;
      m_araddr = 32'h3008; m_arvalid = 1'b1; m_rready = 1'b0;
      tick();
      m_arvalid = 1'b0;
      total++; if (s_arvalid !== 4'b1000) begin bad++; $display("FAIL to_fwd got=%b exp=1000", s_arvalid); end
      n = 0;
      while (m_rvalid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      total++; if (n !== 8) begin bad++; $display("FAIL to_cycles got=%0d exp=8", n); end
      total++; if (m_rresp !== 2'b10 || m_rdata !== 32'h0 || s_arvalid !== 4'b0) begin bad++; $display("FAIL to_resp got=%b/%h/%b exp=10/00000000/0000", m_rresp, m_rdata, s_arvalid); end
      m_rready = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) tick();
      s_rdata[3] = 32'h0000_0BAD; s_rresp[3] = 2'b00; s_rvalid = 4'b1000;
      total++; if (s_rready[3] !== 1'b1) begin bad++; $display("FAIL to_stray_ready got=%b exp=1", s_rready[3]); end
      tick();
      s_rvalid = 4'b0000;
      total++; if (m_rvalid !== 1'b0) begin bad++; $display("FAIL to_stray_dropped got=%b exp=0", m_rvalid); end
      s_rdata[0] = 32'h1111_2222; s_rresp[0] = 2'b00;
      m_araddr = 32'h0010; m_arvalid = 1'b1;
      tick();
      m_arvalid = 1'b0;
      tick();
      s_rvalid = 4'b0001;
      tick();
      s_rvalid = 4'b0000;
      total++; if (m_rvalid !== 1'b1 || m_rresp !== 2'b00 || m_rdata !== 32'h1111_2222) begin bad++; $display("FAIL to_next_read got=%b/%b/%h exp=1/00/11112222", m_rvalid, m_rresp, m_rdata); end
      tick();
   endtask

   task automatic test_concurrent();
      s_bresp[0] = 2'b01; s_rdata[1] = 32'h5555_AAAA; s_rresp[1] = 2'b00;
      s_rdata[2] = 32'h0000_0077; s_rresp[2] = 2'b00;
      m_awaddr = 32'h0040; m_awvalid = 1'b1; m_wdata = 32'hA5A5_A5A5; m_wstrb = 4'hF; m_wvalid = 1'b1;
      m_araddr = 32'h1020; m_arvalid = 1'b1; m_bready = 1'b0; m_rready = 1'b1;
      tick();
      m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;
      total++; if (s_awvalid !== 4'b0001 || s_arvalid !== 4'b0010) begin bad++; $display("FAIL cc_fwd got=%b/%b exp=0001/0010", s_awvalid, s_arvalid); end
      total++; if (s_awaddr[0] !== 32'h040 || s_araddr[1] !== 32'h020) begin bad++; $display("FAIL cc_addr got=%h/%h exp=40/20", s_awaddr[0], s_araddr[1]); end
      tick();
      s_bvalid = 4'b0001; s_rvalid = 4'b0010;
      tick();
      s_bvalid = 4'b0000; s_rvalid = 4'b0000;
      total++; if (m_bvalid !== 1'b1 || m_rvalid !== 1'b1 || m_rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL cc_both got=%b/%b/%h exp=1/1/5555aaaa", m_bvalid, m_rvalid, m_rdata); end
      tick();
      m_araddr = 32'h2100; m_arvalid = 1'b1;
      tick();
      m_arvalid = 1'b0;
      total++; if (s_arvalid !== 4'b0100 || m_bvalid !== 1'b1) begin bad++; $display("FAIL cc_read2_fwd got=%b/%b exp=0100/1", s_arvalid, m_bvalid); end
      tick();
      s_rvalid = 4'b0100;
      tick();
      s_rvalid = 4'b0000;
      total++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h77) begin bad++; $display("FAIL cc_read2_data got=%b/%h exp=1/00000077", m_rvalid, m_rdata); end
      for (int k = 0; k < 6; k++) begin
         total++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b01) begin bad++; $display("FAIL cc_b_hold k=%0d got=%b/%b exp=1/01", k, m_bvalid, m_bresp); end
         tick();
      end
      m_bready = 1'b1;
      tick();
      total++; if (m_bvalid !== 1'b0 || m_rvalid !== 1'b0) begin bad++; $display("FAIL cc_done got=%b/%b exp=0/0", m_bvalid, m_rvalid); end
   endtask

   task automatic test_reset_mid();
      m_awaddr = 32'h3000; m_awvalid = 1'b1; m_wdata = 32'h0F0F_0F0F; m_wvalid = 1'b1;
      m_araddr = 32'h0004; m_arvalid = 1'b1;
      tick();
      m_awvalid = 1'b0; m_wvalid = 1'b0; m_arvalid = 1'b0;
      tick();
      total++; if (s_bready !== 4'b1000 || s_rready !== 4'b0001) begin bad++; $display("FAIL rm_wait got=%b/%b exp=1000/0001", s_bready, s_rready); end
      rst = 1'b1;
      tick();
      total++; if ({s_awvalid, s_wvalid, s_arvalid, m_bvalid, m_rvalid} !== 14'b0) begin bad++; $display("FAIL rm_valids got=%b exp=0", {s_awvalid, s_wvalid, s_arvalid, m_bvalid, m_rvalid}); end
      rst = 1'b0;
      tick();
      tick();
      total++; if ({m_awready, m_wready, m_arready} !== 3'b111) begin bad++; $display("FAIL rm_idle got=%b exp=111", {m_awready, m_wready, m_arready}); end
      m_awaddr = 32'h2008; m_awvalid = 1'b1; m_wdata = 32'h0BAD_CAFE; m_wvalid = 1'b1;
      tick();
      m_awvalid = 1'b0; m_wvalid = 1'b0;
      total++; if (s_awvalid !== 4'b0100 || s_awaddr[2] !== 32'h008) begin bad++; $display("FAIL rm_fresh_fwd got=%b/%h exp=0100/00000008", s_awvalid, s_awaddr[2]); end
      tick();
      s_bresp[2] = 2'b00; s_bvalid = 4'b0100;
      tick();
      s_bvalid = 4'b0000;
      total++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b00) begin bad++; $display("FAIL rm_fresh_b got=%b/%b exp=1/00", m_bvalid, m_bresp); end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0; m_bready = 1'b0;
      m_araddr = '0; m_arvalid = 1'b0; m_rready = 1'b0;
      s_awready = '1; s_wready = '1; s_arready = '1;
      s_bresp = '0; s_bvalid = '0; s_rdata = '0; s_rresp = '0; s_rvalid = '0;
      test_reset();
      test_write_same_cycle();
      test_w_before_aw();
      test_read_ok();
      test_read_decerr();
      test_timeout();
      test_concurrent();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
